// File: rtl/d8_data_mem_responder_if.sv
// d8_data_mem_responder_if
//   Bundles the core-side request/response signals and the RAM-side
//   signals of the d8 data-memory responder.
//   Core side : req, w, addr, wdata (to responder); rdata, ack, busy (back)
//   RAM side  : mem_en, mem_we, mem_addr, mem_wdata (to RAM); mem_rdata (back)
//   slave  : the responder itself
//   master : the environment around it (core plus RAM)
interface d8_data_mem_responder_if #(
   parameter int unsigned AW = 8
);
   logic          req;
   logic          w;
   logic [AW-1:0] addr;
   logic [7:0]    wdata;
   logic [7:0]    rdata;
   logic          ack;
   logic          busy;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata;

   modport slave (
      input  req, w, addr, wdata, mem_rdata,
      output rdata, ack, busy, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req, w, addr, wdata, mem_rdata,
      input  rdata, ack, busy, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/d8_data_mem_responder.sv
// d8_data_mem_responder
//   Responder end of the d8 core's data-memory port. Accepts one request
//   in IDLE, drives a single-port synchronous RAM (one-cycle read latency)
//   for exactly one enable cycle, captures load data, optionally inserts
//   WAIT extra cycles, then pulses ack for one cycle.
//   Ports:
//     sys_clk    rising-edge clock
//     sys_rst_n  asynchronous active-low reset
//     bus        d8_data_mem_responder_if.slave (core + RAM signals)
//   Parameters:
//     AW    address width (must match the interface instance)
//     WAIT  extra wait cycles before ack, 0..15
//   Every output is a flop; there is no input-to-output combinational path.
module d8_data_mem_responder #(
   parameter int unsigned AW   = 8,
   parameter int unsigned WAIT = 0
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   d8_data_mem_responder_if.slave bus
);

   // The wait counter is 4 bits wide; WAIT above 15 is not supported.
   localparam logic [3:0] WAIT_CNT = 4'(WAIT);

   typedef enum logic [2:0] {
      IDLE,
      ACCESS,
      LATCH,
      WAITS,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic          dir_q, dir_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [7:0]    rdata_q, rdata_d;
   logic          ack_q, ack_d;
   logic          busy_q, busy_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]    mem_wdata_q, mem_wdata_d;

   // State and all registered outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         dir_q       <= 1'b0;
         cnt_q       <= 4'd0;
         rdata_q     <= 8'h00;
         ack_q       <= 1'b0;
         busy_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         cnt_q       <= cnt_d;
         rdata_q     <= rdata_d;
         ack_q       <= ack_d;
         busy_q      <= busy_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Next state and next values of every registered output.
   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      ack_d       = ack_q;
      busy_d      = busy_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         IDLE: begin
            // Request is taken only here; everything used later is a
            // latched copy, so the core may change its inputs freely.
            if (bus.req) begin
               state_d     = ACCESS;
               mem_addr_d  = bus.addr;
               mem_wdata_d = bus.wdata;
               dir_d       = bus.w;
               mem_en_d    = 1'b1;
               mem_we_d    = bus.w;
               busy_d      = 1'b1;
            end
         end

         ACCESS: begin
            // The single RAM enable cycle is this one.
            state_d  = LATCH;
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
         end

         LATCH: begin
            // RAM read data is valid now, one cycle after the enable.
            if (!dir_q) rdata_d = bus.mem_rdata;
            cnt_d = WAIT_CNT;
            if (WAIT_CNT != 4'd0) begin
               state_d = WAITS;
            end else begin
               state_d = DONE;
               ack_d   = 1'b1;
            end
         end

         WAITS: begin
            // Entered with cnt=WAIT; leaving when cnt==1 gives WAIT cycles.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = DONE;
               ack_d   = 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
            ack_d   = 1'b0;
            busy_d  = 1'b0;
         end

         default: begin
            state_d  = IDLE;
            ack_d    = 1'b0;
            busy_d   = 1'b0;
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
         end
      endcase
   end

   assign bus.rdata     = rdata_q;
   assign bus.ack       = ack_q;
   assign bus.busy      = busy_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_d8_data_mem_responder.sv
// Bench for d8_data_mem_responder: two instances (WAIT=0 and WAIT=3), each
// with its own RAM model. Stimulus pushes expected RAM accesses and acks
// into per-instance queues; a negedge monitor pops and compares them.
module tb_d8_data_mem_responder;

   logic sys_clk;
   logic sys_rst_n;

   d8_data_mem_responder_if #(.AW(8)) bus0 ();
   d8_data_mem_responder_if #(.AW(8)) bus1 ();

   d8_data_mem_responder #(.AW(8), .WAIT(0)) dut0 (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .bus      (bus0)
   );

   d8_data_mem_responder #(.AW(8), .WAIT(3)) dut1 (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .bus      (bus1)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int vectors    = 0;
   int miscompares = 0;

   // Drive side
   logic [1:0]      req_v, w_v;
   logic [1:0][7:0] addr_v, wdata_v, ram_rd;

   assign bus0.req = req_v[0];  assign bus1.req = req_v[1];
   assign bus0.w   = w_v[0];    assign bus1.w   = w_v[1];
   assign bus0.addr  = addr_v[0];  assign bus1.addr  = addr_v[1];
   assign bus0.wdata = wdata_v[0]; assign bus1.wdata = wdata_v[1];
   assign bus0.mem_rdata = ram_rd[0];
   assign bus1.mem_rdata = ram_rd[1];

   // Observe side
   logic [1:0]      ack_o, busy_o, en_o, we_o;
   logic [1:0][7:0] rd_o, ma_o, mwd_o;

   assign ack_o  = {bus1.ack, bus0.ack};
   assign busy_o = {bus1.busy, bus0.busy};
   assign en_o   = {bus1.mem_en, bus0.mem_en};
   assign we_o   = {bus1.mem_we, bus0.mem_we};
   assign rd_o   = {bus1.rdata, bus0.rdata};
   assign ma_o   = {bus1.mem_addr, bus0.mem_addr};
   assign mwd_o  = {bus1.mem_wdata, bus0.mem_wdata};

   // RAM models: single port, one-cycle read latency.
   logic [7:0] ram0 [256];
   logic [7:0] ram1 [256];

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram0[i] = 8'h00;
         ram1[i] = 8'h00;
      end
      ram_rd = '0;
   end

   always @(posedge sys_clk) begin
      if (bus0.mem_en) begin
         if (bus0.mem_we) ram0[bus0.mem_addr] <= bus0.mem_wdata;
         else             ram_rd[0] <= ram0[bus0.mem_addr];
      end
      if (bus1.mem_en) begin
         if (bus1.mem_we) ram1[bus1.mem_addr] <= bus1.mem_wdata;
         else             ram_rd[1] <= ram1[bus1.mem_addr];
      end
   end

   // Scoreboard
   typedef struct {
      int         cyc;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wd;
   } mem_t;

   typedef struct {
      int         cyc;
      logic [7:0] rd;
      int         bfrom;
   } ack_t;

   mem_t mem_q [2][$];
   ack_t ack_q [2][$];

   logic [1:0] prev_ack  = '0;
   logic [1:0] busy_prev = '0;
   int         busy_since [2];

   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         prev_ack  = '0;
         busy_prev = '0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (we_o[d] && !en_o[d]) begin
               miscompares++;
               $display("FAIL we_without_en dut%0d cyc=%0d", d, cyc);
            end
            if (busy_o[d] && !busy_prev[d]) busy_since[d] = cyc;
            if (prev_ack[d]) begin
               vectors++;
               if (busy_o[d] !== 1'b0 || ack_o[d] !== 1'b0) begin
                  miscompares++;
                  $display("FAIL post_ack_idle dut%0d cyc=%0d busy=%b ack=%b want 0/0",
                           d, cyc, busy_o[d], ack_o[d]);
               end
            end
            if (en_o[d]) begin
               vectors++;
               if (mem_q[d].size() == 0) begin
                  miscompares++;
                  $display("FAIL unexpected_mem_en dut%0d cyc=%0d addr=%h", d, cyc, ma_o[d]);
               end else begin
                  mem_t m;
                  m = mem_q[d].pop_front();
                  if (m.cyc != cyc || we_o[d] !== m.we || ma_o[d] !== m.addr || mwd_o[d] !== m.wd) begin
                     miscompares++;
                     $display("FAIL mem_access dut%0d got cyc=%0d we=%b addr=%h wd=%h want cyc=%0d we=%b addr=%h wd=%h",
                              d, cyc, we_o[d], ma_o[d], mwd_o[d], m.cyc, m.we, m.addr, m.wd);
                  end
               end
            end
            if (ack_o[d]) begin
               vectors++;
               if (ack_q[d].size() == 0) begin
                  miscompares++;
                  $display("FAIL unexpected_ack dut%0d cyc=%0d", d, cyc);
               end else begin
                  ack_t a;
                  a = ack_q[d].pop_front();
                  if (a.cyc != cyc || rd_o[d] !== a.rd || busy_o[d] !== 1'b1 || busy_since[d] != a.bfrom) begin
                     miscompares++;
                     $display("FAIL ack dut%0d got cyc=%0d rdata=%h busy=%b busy_from=%0d want cyc=%0d rdata=%h busy=1 busy_from=%0d",
                              d, cyc, rd_o[d], busy_o[d], busy_since[d], a.cyc, a.rd, a.bfrom);
                  end
               end
            end
            prev_ack[d]  = ack_o[d];
            busy_prev[d] = busy_o[d];
         end
      end
   end

   // Call right after a negedge; req is sampled at the next posedge.
   task automatic issue(input int d, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, input logic [7:0] exp_rd,
                        input int wt, input bit exp_ack);
      mem_t m;
      ack_t k;
      req_v[d] = 1'b1; w_v[d] = wr; addr_v[d] = a; wdata_v[d] = wd;
      m.cyc = cyc + 1; m.we = wr; m.addr = a; m.wd = wd;
      mem_q[d].push_back(m);
      if (exp_ack) begin
         k.cyc = cyc + 3 + wt; k.rd = exp_rd; k.bfrom = cyc + 1;
         ack_q[d].push_back(k);
      end
      @(negedge sys_clk);
      // Scramble inputs: only latched copies may be used.
      req_v[d] = 1'b0; w_v[d] = ~wr; addr_v[d] = ~a; wdata_v[d] = wd ^ 8'h5A;
   endtask

   task automatic check_zero(input int d, input string tag);
      vectors++;
      if (rd_o[d] !== 8'h00 || ack_o[d] !== 1'b0 || busy_o[d] !== 1'b0 ||
          en_o[d] !== 1'b0 || we_o[d] !== 1'b0 || ma_o[d] !== 8'h00 || mwd_o[d] !== 8'h00) begin
         miscompares++;
         $display("FAIL %s dut%0d rdata=%h ack=%b busy=%b en=%b we=%b addr=%h wd=%h want all 0",
                  tag, d, rd_o[d], ack_o[d], busy_o[d], en_o[d], we_o[d], ma_o[d], mwd_o[d]);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   initial begin
      int c;
      req_v = '0; w_v = '0; addr_v = '0; wdata_v = '0;
      sys_rst_n = 1'b1;
      #2 sys_rst_n = 1'b0;
      #1 check_zero(0, "reset_state");
      check_zero(1, "reset_state");
      idle(3);
      sys_rst_n = 1'b1;
      idle(1);

      // WAIT=0: write then read back, rdata unchanged on write
      issue(0, 1'b1, 8'h3C, 8'hA5, 8'h00, 0, 1'b1); idle(5);
      issue(0, 1'b0, 8'h3C, 8'h00, 8'hA5, 0, 1'b1); idle(5);
      issue(0, 1'b1, 8'hFF, 8'hC3, 8'hA5, 0, 1'b1); idle(5);
      issue(0, 1'b0, 8'hFF, 8'h00, 8'hC3, 0, 1'b1); idle(5);

      // WAIT=3: ack at N+6, busy from N+1
      issue(1, 1'b1, 8'hFF, 8'h5A, 8'h00, 3, 1'b1); idle(9);
      issue(1, 1'b0, 8'hFF, 8'h00, 8'h5A, 3, 1'b1); idle(9);
      issue(1, 1'b1, 8'h00, 8'h77, 8'h5A, 3, 1'b1); idle(9);
      issue(1, 1'b0, 8'h00, 8'h00, 8'h77, 3, 1'b1); idle(9);

      // Back-to-back with req held: write 10<-11 then read 10
      begin
         mem_t m;
         ack_t k;
         c = cyc;
         req_v[0] = 1'b1; w_v[0] = 1'b1; addr_v[0] = 8'h10; wdata_v[0] = 8'h11;
         m.cyc = c + 1; m.we = 1'b1; m.addr = 8'h10; m.wd = 8'h11; mem_q[0].push_back(m);
         k.cyc = c + 3; k.rd = 8'hC3; k.bfrom = c + 1; ack_q[0].push_back(k);
         m.cyc = c + 5; m.we = 1'b0; m.addr = 8'h10; m.wd = 8'hFF; mem_q[0].push_back(m);
         k.cyc = c + 7; k.rd = 8'h11; k.bfrom = c + 5; ack_q[0].push_back(k);
         @(negedge sys_clk);
         w_v[0] = 1'b0; addr_v[0] = 8'h10; wdata_v[0] = 8'hFF;
         idle(4);
         req_v[0] = 1'b0;
         idle(8);
      end

      // Reset during LATCH of a read: no ack, rdata cleared
      issue(0, 1'b0, 8'h10, 8'h00, 8'h00, 0, 1'b0);
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      #1 check_zero(0, "reset_mid_latch");
      check_zero(1, "reset_mid_latch");
      @(negedge sys_clk);
      check_zero(0, "reset_hold");
      sys_rst_n = 1'b1;
      // Accepted on the first edge after release
      issue(0, 1'b0, 8'h3C, 8'h00, 8'hA5, 0, 1'b1); idle(5);
      issue(1, 1'b0, 8'hFF, 8'h00, 8'h5A, 3, 1'b1); idle(10);

      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (mem_q[d].size() != 0) begin
            miscompares++;
            $display("FAIL missing_mem_access dut%0d left=%0d want 0", d, mem_q[d].size());
         end
         vectors++;
         if (ack_q[d].size() != 0) begin
            miscompares++;
            $display("FAIL missing_ack dut%0d left=%0d want 0", d, ack_q[d].size());
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/d8_data_mem_responder.md
Name: d8_data_mem_responder

Overview:
- Responder end of the core's data-memory access interface.
- The opcode decode produces the write/read direction bit. This block accepts the core's request, sequences a single-port synchronous data RAM (one-cycle read latency), returns read data, and acknowledges completion.
- It sits between the d8 core's data port and the data RAM, and supports a fixed number of programmable wait states.

Parameters:
- AW, 8: data address width in bits.
- WAIT, 0: extra wait cycles inserted before ack. Legal range 0..15; the internal counter is 4 bits.

Ports:
- sys_clk  in  1  system clock; everything is sampled on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- req  in  1  core access request; sampled only in IDLE.
- w  in  1  direction from the opcode decode: 1 = store (write), 0 = load (read).
- addr  in  AW  core data address.
- wdata  in  8  core store data.
- rdata  out  8  load result; registered.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high while a transaction is in progress (every state except IDLE).
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data; valid the cycle after mem_en.

Behaviour:
- Reset (async, sys_rst_n=0):
  - State goes to IDLE.
  - rdata=8'h00, ack=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, wait counter=0.
  - Reset is released synchronously into IDLE.
- All outputs are registered. There is no combinational path from any input to any output.
- FSM states: IDLE, ACCESS, LATCH, WAITS, DONE.
- IDLE:
  - When req=1 at an edge: latch addr→mem_addr, wdata→mem_wdata, w→internal dir; set mem_en=1, mem_we=w, busy=1; go to ACCESS.
  - When req=0: hold.
- ACCESS (exactly 1 cycle):
  - mem_en=1 and mem_we=dir are visible.
  - Next state is LATCH, with mem_en and mem_we cleared to 0.
- LATCH (exactly 1 cycle):
  - If dir=0: rdata<=mem_rdata at the end of this cycle.
  - If dir=1: rdata is unchanged.
  - Load the counter with WAIT. Go to WAITS if WAIT>0, else go to DONE with ack<=1.
- WAITS:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to DONE with ack<=1.
  - Exactly WAIT cycles are spent in this state.
- DONE (exactly 1 cycle):
  - ack=1 and busy=1.
  - Next state is IDLE, with ack<=0 and busy<=0.
- Timing, with req sampled at edge N:
  - ACCESS is cycle N+1.
  - LATCH is cycle N+2.
  - ack is high in cycle N+3+WAIT.
  - rdata is valid from cycle N+3 and is held until the next load completes.
- Throughput:
  - req in DONE or any busy state is ignored; it is not queued.
  - req held high through DONE starts a new transaction at the first IDLE edge.
  - Minimum request-to-request period is 4+WAIT cycles.
- Inputs addr, wdata and w may change freely after the IDLE sampling edge. Only the latched copies are used.
- The RAM sees exactly one mem_en cycle per transaction and never a write with mem_en=0.
- Reset mid-transaction:
  - Outputs clear immediately; no ack is issued.
  - A write whose mem_we edge already occurred stands. Otherwise no write happens.
  - rdata returns to 0.
- Address wrap: addr is used verbatim. Widths match, so there is no truncation or extension.

Test Plan:
- Reset: assert sys_rst_n=0 mid-run → all outputs 0 immediately (asynchronously); after release, busy=0 and the block accepts req on the first edge.
- Write, WAIT=0: req=1, w=1, addr=8'h3C, wdata=8'hA5 at edge N → mem_en=mem_we=1, mem_addr=3C, mem_wdata=A5 in cycle N+1 only; ack in N+3; rdata unchanged.
- Read, WAIT=0: the RAM model returns A5 from addr 3C → mem_en=1, mem_we=0 in N+1; rdata=8'hA5 from N+3; ack in N+3.
- Wait states, WAIT=3: read of addr 8'hFF → ack in N+6 exactly; busy high during N+1..N+6; one single mem_en pulse.
- Back-to-back with req held high: write 0x10←0x11, then read 0x10 → second mem_en at N+5; second ack at N+7 with rdata=8'h11; req during busy not queued.
- Reset during LATCH of a read → no ack, rdata=0; a subsequent read completes normally with correct data.
